// File: rtl/led_serial_rx_pkg.sv
// Shared types and defaults for the LED serial link receiver.
// No logic; imported by the receiver top.
// State encoding and default frame geometry live here.
package led_serial_rx_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOW = 2'd0,
        ST_IDLE     = 2'd1,
        ST_SHIFT    = 2'd2
    } state_t;

    localparam int DATA_W_DEF      = 24;
    localparam int MAX_BITS_DEF    = 26;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int TIMEOUT_DEF     = 1023;

endpackage

// File: rtl/led_sync_edge.sv
// Synchronizes one asynchronous pin and reports its level plus rise/fall events.
// Latency: STAGES+1 CLK cycles from pin to registered rise/fall; level is aligned with them.
// No backpressure: rise/fall are single-cycle pulses.
module led_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              prev_q, prev_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;

    // Shift the pin through the chain and compare the last stage with its delayed copy.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
        rise_d = sync_q[STAGES-1] & ~prev_q;
        fall_d = ~sync_q[STAGES-1] & prev_q;
    end

    // Reset value is configurable so a pin can be assumed asserted until proven low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign level = prev_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/led_serial_rx.sv
// Deserializes the LED_CLK/LED_OUT/LED_OE frame into a parallel word, MSB first.
// Latency: DATA_VALID/ERR_* appear SYNC_STAGES+2 CLK cycles after the causing pin event.
// No backpressure: results are one-cycle pulses; DATA_OUT holds the last good word.
module led_serial_rx
    import led_serial_rx_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int MAX_BITS    = MAX_BITS_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int TIMEOUT     = TIMEOUT_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SCLK,
    input  logic              SDATA,
    input  logic              SFRAME,
    output logic [DATA_W-1:0] DATA_OUT,
    output logic              DATA_VALID,
    output logic              ERR_SHORT,
    output logic              ERR_LONG,
    output logic              ERR_TIMEOUT,
    output logic              BUSY
);

    localparam int CNT_W = $clog2(MAX_BITS + 2);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_BITS + 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    logic sclk_rise, sclk_level_unused, sclk_fall_unused;
    logic frame_lvl, frame_rise, frame_fall;

    led_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk   (CLK),
        .rst   (RST),
        .din   (SCLK),
        .level (sclk_level_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall_unused)
    );

    // SFRAME resets as "high" so a frame already in flight at reset release is waited out.
    led_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_frame_sync (
        .clk   (CLK),
        .rst   (RST),
        .din   (SFRAME),
        .level (frame_lvl),
        .rise  (frame_rise),
        .fall  (frame_fall)
    );

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [TO_W-1:0]         to_q, to_d;
    logic [DATA_W-1:0]       shift_q, shift_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic [SYNC_STAGES-1:0]  sdata_sync_q, sdata_sync_d;
    logic                    sdata_bit_q, sdata_bit_d;
    logic                    valid_q, valid_d;
    logic                    err_short_q, err_short_d;
    logic                    err_long_q, err_long_d;
    logic                    err_to_q, err_to_d;
    logic                    busy_q, busy_d;

    // Frame FSM: SDATA is tapped from the same depth as SCLK and delayed once more to line up with sclk_rise.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        to_d         = to_q;
        shift_d      = shift_q;
        data_d       = data_q;
        valid_d      = 1'b0;
        err_short_d  = 1'b0;
        err_long_d   = 1'b0;
        err_to_d     = 1'b0;
        sdata_sync_d = {sdata_sync_q[SYNC_STAGES-2:0], SDATA};
        sdata_bit_d  = sdata_sync_q[SYNC_STAGES-1];

        case (state_q)
            ST_WAIT_LOW: begin
                if (!frame_lvl) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (frame_rise) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    to_d    = '0;
                    shift_d = '0;
                    // A clock edge coinciding with the frame start is bit 0.
                    if (sclk_rise) begin
                        shift_d = DATA_W'(sdata_bit_q);
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_SHIFT: begin
                // Frame end wins over a simultaneous clock edge, which is dropped.
                if (frame_fall) begin
                    state_d = ST_IDLE;
                    if (cnt_q < CNT_DATA) begin
                        err_short_d = 1'b1;
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end else if (sclk_rise) begin
                    to_d = '0;
                    if (cnt_q < CNT_DATA) shift_d = {shift_q[DATA_W-2:0], sdata_bit_q};
                    if (cnt_q >= CNT_MAX) begin
                        cnt_d      = CNT_SAT;
                        err_long_d = 1'b1;
                        state_d    = ST_WAIT_LOW;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (to_q == TO_LAST) begin
                    err_to_d = 1'b1;
                    state_d  = ST_WAIT_LOW;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            default: state_d = ST_WAIT_LOW;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // All state and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_WAIT_LOW;
            cnt_q        <= '0;
            to_q         <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            sdata_sync_q <= '0;
            sdata_bit_q  <= 1'b0;
            valid_q      <= 1'b0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
            err_to_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            to_q         <= to_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            sdata_sync_q <= sdata_sync_d;
            sdata_bit_q  <= sdata_bit_d;
            valid_q      <= valid_d;
            err_short_q  <= err_short_d;
            err_long_q   <= err_long_d;
            err_to_q     <= err_to_d;
            busy_q       <= busy_d;
        end
    end

    assign DATA_OUT    = data_q;
    assign DATA_VALID  = valid_q;
    assign ERR_SHORT   = err_short_q;
    assign ERR_LONG    = err_long_q;
    assign ERR_TIMEOUT = err_to_q;
    assign BUSY        = busy_q;

endmodule

// File: tb/tb_led_serial_rx.sv
// Bench for led_serial_rx: frame-level model schedules expected pulses/word per cycle.
// Latency: pulses expected SYNC_STAGES+2 cycles after the pin event that causes them.
// Inputs are driven on the falling CLK edge, outputs sampled 1 time unit after the rising edge.
module tb_led_serial_rx;

    localparam int DW  = 24;
    localparam int MB  = 26;
    localparam int SS  = 2;
    localparam int TO  = 1023;
    localparam int LAT = SS + 2;

    logic          CLK = 1'b0;
    logic          RST, SCLK, SDATA, SFRAME;
    logic [DW-1:0] DATA_OUT;
    logic          DATA_VALID, ERR_SHORT, ERR_LONG, ERR_TIMEOUT, BUSY;

    always #5 CLK = ~CLK;

    led_serial_rx #(.DATA_W(DW), .MAX_BITS(MB), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .SCLK        (SCLK),
        .SDATA       (SDATA),
        .SFRAME      (SFRAME),
        .DATA_OUT    (DATA_OUT),
        .DATA_VALID  (DATA_VALID),
        .ERR_SHORT   (ERR_SHORT),
        .ERR_LONG    (ERR_LONG),
        .ERR_TIMEOUT (ERR_TIMEOUT),
        .BUSY        (BUSY)
    );

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Expected pulses {dv, short, long, timeout} and word, keyed by sample cycle.
    logic [3:0]    exp_ev   [int];
    logic [DW-1:0] exp_word [int];

    // Frame-level model state.
    bit            m_active = 0;
    bit            m_blocked = 0;
    int            m_edges = 0;
    int            m_last = 0;
    logic [DW-1:0] m_shift = '0;
    logic [DW-1:0] m_data = '0;

    // Observations of the DUT, compared later against literals.
    int            dv_count = 0, short_count = 0, long_count = 0, to_count = 0;
    int            last_dv_cyc = 0, last_to_cyc = 0, last_rise_cyc = 0, fall_cyc = 0;
    logic [DW-1:0] dv_words [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Per-cycle compare against the model schedule.
    initial begin : compare
        logic [3:0] want;
        forever begin
            @(posedge CLK);
            cyc++;
            #1;
            want = exp_ev.exists(cyc) ? exp_ev[cyc] : 4'b0000;
            check("pulses", {28'd0, DATA_VALID, ERR_SHORT, ERR_LONG, ERR_TIMEOUT}, {28'd0, want});
            if (RST) m_data = '0;
            else if (want[3]) m_data = exp_word[cyc];
            check("data_out", {8'd0, DATA_OUT}, {8'd0, m_data});
            if (DATA_VALID) begin
                dv_count++;
                last_dv_cyc = cyc;
                dv_words.push_back(DATA_OUT);
            end
            if (ERR_SHORT) short_count++;
            if (ERR_LONG) long_count++;
            if (ERR_TIMEOUT) begin
                to_count++;
                last_to_cyc = cyc;
            end
        end
    end

    task automatic sched(input int key, input logic [3:0] ev, input logic [DW-1:0] w);
        exp_ev[key]   = ev;
        exp_word[key] = w;
    endtask

    // Advance to the next drive point; a framed link silent for more than TO cycles times out.
    task automatic tick();
        @(negedge CLK);
        if (m_active && (cyc - m_last) > TO) begin
            sched(m_last + LAT + TO, 4'b0001, '0);
            m_active  = 0;
            m_blocked = 1;
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) tick();
    endtask

    task automatic set_frame(input logic v);
        if (v && !SFRAME) begin
            if (!m_blocked) begin
                m_active = 1;
                m_edges  = 0;
                m_last   = cyc;
                m_shift  = '0;
            end
        end else if (!v && SFRAME) begin
            fall_cyc = cyc;
            if (m_active) begin
                if (m_edges < DW) sched(cyc + LAT, 4'b0100, '0);
                else              sched(cyc + LAT, 4'b1000, m_shift);
            end
            m_active  = 0;
            m_blocked = 0;
        end
        SFRAME = v;
    endtask

    task automatic set_sclk(input logic v, input logic d);
        SDATA = d;
        if (v && !SCLK) begin
            last_rise_cyc = cyc;
            if (m_active) begin
                m_edges++;
                m_last = cyc;
                if (m_edges <= DW) m_shift = {m_shift[DW-2:0], d};
                if (m_edges > MB) begin
                    sched(cyc + LAT, 4'b0010, '0);
                    m_active  = 0;
                    m_blocked = 1;
                end
            end
        end
        SCLK = v;
    endtask

    // MSB-first bits at CLK/8; bits past the word are zero trailing clocks.
    task automatic send_bits(input logic [DW-1:0] w, input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            b = (i < DW) ? w[DW-1-i] : 1'b0;
            set_sclk(1'b0, b);
            wait_cyc(4);
            set_sclk(1'b1, b);
            wait_cyc(4);
        end
    endtask

    task automatic frame(input logic [DW-1:0] w, input int n);
        set_frame(1'b1);
        wait_cyc(4);
        send_bits(w, n);
        set_sclk(1'b0, 1'b0);
        wait_cyc(4);
        set_frame(1'b0);
    endtask

    task automatic do_reset(input int n);
        int keys [$];
        RST      = 1'b1;
        m_active = 0;
        foreach (exp_ev[k]) if (k > cyc) keys.push_back(k);
        foreach (keys[i]) begin
            exp_ev.delete(keys[i]);
            exp_word.delete(keys[i]);
        end
        wait_cyc(n);
        RST       = 1'b0;
        m_blocked = SFRAME;
    endtask

    initial begin : stim
        RST = 1'b1; SCLK = 1'b0; SDATA = 1'b0; SFRAME = 1'b0;
        wait_cyc(3);
        check("rst_data_out", {8'd0, DATA_OUT}, 32'd0);
        check("rst_pulses", {28'd0, DATA_VALID, ERR_SHORT, ERR_LONG, ERR_TIMEOUT}, 32'd0);
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        RST = 1'b0;
        wait_cyc(10);
        check("idle_busy", {31'd0, BUSY}, 32'd0);

        // Plain 24-bit frame and its exact latency.
        frame(24'hA5C30F, 24);
        wait_cyc(12);
        check("t1_dv_count", dv_count, 1);
        check("t1_latency", last_dv_cyc - fall_cyc, 4);
        check("t1_word", {8'd0, DATA_OUT}, 32'h00A5C30F);

        // 26 edges (two trailing clocks) is still good.
        frame(24'h5A3C96, 26);
        wait_cyc(12);
        check("t2_dv_count", dv_count, 2);
        check("t2_word", {8'd0, DATA_OUT}, 32'h005A3C96);

        // 27 edges: overlong, receiver stays busy until the frame drops.
        set_frame(1'b1);
        wait_cyc(4);
        send_bits(24'h111111, 27);
        wait_cyc(10);
        check("t3_long_count", long_count, 1);
        check("t3_busy_held", {31'd0, BUSY}, 32'd1);
        set_frame(1'b0);
        wait_cyc(10);
        check("t3_busy_clear", {31'd0, BUSY}, 32'd0);
        check("t3_dv_count", dv_count, 2);

        // 20 edges: short frame keeps the previous word.
        frame(24'hFEDCBA, 20);
        wait_cyc(12);
        check("t4_short_count", short_count, 1);
        check("t4_word_kept", {8'd0, DATA_OUT}, 32'h005A3C96);

        // Stall after 10 edges: timeout, then edges ignored until the frame drops.
        set_frame(1'b1);
        wait_cyc(4);
        send_bits(24'hFFFFFF, 10);
        begin : stall
            int rise_at;
            rise_at = last_rise_cyc;
            wait_cyc(TO + 20);
            check("t5_to_count", to_count, 1);
            check("t5_to_latency", last_to_cyc - rise_at, 1027);
        end
        check("t5_busy_wait_low", {31'd0, BUSY}, 32'd1);
        send_bits(24'hFFFFFF, 3);
        set_frame(1'b0);
        wait_cyc(8);
        frame(24'h000001, 24);
        wait_cyc(12);
        check("t5_dv_count", dv_count, 3);
        check("t5_word", {8'd0, DATA_OUT}, 32'h00000001);

        // Reset after 12 bits, frame finishes after release: nothing reported.
        set_frame(1'b1);
        wait_cyc(4);
        send_bits(24'h0F0F0F, 12);
        do_reset(2);
        send_bits(24'h0F0F0F, 12);
        set_sclk(1'b0, 1'b0);
        wait_cyc(4);
        set_frame(1'b0);
        wait_cyc(12);
        check("t6_no_dv", dv_count, 3);
        check("t6_no_short", short_count, 1);
        check("t6_word_cleared", {8'd0, DATA_OUT}, 32'd0);
        frame(24'hFFFFFF, 24);
        wait_cyc(12);
        check("t6_word", {8'd0, DATA_OUT}, 32'h00FFFFFF);

        // Back-to-back: one SCLK period gap, then a one-cycle gap.
        frame(24'h123456, 24);
        wait_cyc(8);
        frame(24'hABCDEF, 24);
        wait_cyc(1);
        frame(24'h5A5A5A, 24);
        wait_cyc(12);
        check("t7_dv_count", dv_count, 7);
        if (dv_words.size() >= 7) begin
            check("t7_word0", {8'd0, dv_words[4]}, 32'h00123456);
            check("t7_word1", {8'd0, dv_words[5]}, 32'h00ABCDEF);
            check("t7_word2", {8'd0, dv_words[6]}, 32'h005A5A5A);
        end else begin
            check("t7_words_seen", dv_words.size(), 7);
        end
        check("end_short_count", short_count, 1);
        check("end_long_count", long_count, 1);
        check("end_to_count", to_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
